// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with HI/LO result registers.
// Shift-add multiply, restoring divide, sign fix-up in a final cycle.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt;
   logic             is_div, neg_q, neg_r, dz_q;
   logic [WIDTH-1:0] bq, acc, lw;

   logic             sgn;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   sum, shifted;
   logic             ge;
   logic [WIDTH-1:0] sub, acc_n, lw_n;
   logic [2*WIDTH-1:0] prod, prod_f;
   logic [WIDTH-1:0] q_f, r_f, hi_f, lo_f;

   always_comb begin
      sgn   = ~op[0];
      a_mag = (sgn && a[WIDTH-1]) ? -a : a;
      b_mag = (sgn && b[WIDTH-1]) ? -b : b;
   end

   // One iteration: {acc,lw} is the product or the {rem,quot} pair
   always_comb begin
      sum     = {1'b0, acc} + (lw[0] ? {1'b0, bq} : '0);
      shifted = {acc, lw[WIDTH-1]};
      ge      = shifted >= {1'b0, bq};
      sub     = shifted[WIDTH-1:0] - bq;
      acc_n   = '0;
      lw_n    = '0;
      if (is_div) begin
         acc_n = ge ? sub : shifted[WIDTH-1:0];
         lw_n  = {lw[WIDTH-2:0], ge};
      end else begin
         acc_n = sum[WIDTH:1];
         lw_n  = {sum[0], lw[WIDTH-1:1]};
      end
   end

   always_comb begin
      prod   = {acc, lw};
      prod_f = neg_q ? -prod : prod;
      q_f    = neg_q ? -lw : lw;
      r_f    = neg_r ? -acc : acc;
      hi_f   = is_div ? r_f : prod_f[2*WIDTH-1:WIDTH];
      lo_f   = is_div ? q_f : prod_f[WIDTH-1:0];
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (start)
            state_d = (op[1] && b == '0) ? FIX : CALC;
         CALC: if (cnt == CNT_W'(1)) state_d = FIX;
         FIX:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         cnt      <= '0;
         is_div   <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         dz_q     <= 1'b0;
         bq       <= '0;
         acc      <= '0;
         lw       <= '0;
      end else begin
         done <= 1'b0;
         unique case (state_q)
            IDLE: if (start) begin
               is_div   <= op[1];
               neg_q    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_r    <= sgn & a[WIDTH-1];
               dz_q     <= op[1] & (b == '0);
               div_zero <= 1'b0;
               busy     <= 1'b1;
               cnt      <= CNT_W'(WIDTH);
               acc      <= '0;
               lw       <= op[1] ? a_mag : b_mag;
               bq       <= op[1] ? b_mag : a_mag;
            end
            CALC: begin
               acc <= acc_n;
               lw  <= lw_n;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: begin
               busy <= 1'b0;
               done <= 1'b1;
               if (dz_q) begin
                  div_zero <= 1'b1;
               end else begin
                  hi <= hi_f;
                  lo <= lo_f;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vector table, corner sequences
// and random operations against an arithmetic reference model.
module tb_mult_div_unit;

   logic        clock, reset, start;
   logic [1:0]  op;
   logic [31:0] a, b;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int total = 0;
   int bad   = 0;

   logic [31:0] mhi = '0;
   logic [31:0] mlo = '0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b, hi, lo;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t tv[9];

   mult_div_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic model(input logic [1:0] o, input logic [31:0] x, y,
                        inout logic [31:0] h, l, output logic dz);
      longint sx, sy, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      dz = 1'b0;
      case (o)
         2'd0: begin p = 64'(sx * sy); h = p[63:32]; l = p[31:0]; end
         2'd1: begin p = {32'b0, x} * {32'b0, y}; h = p[63:32]; l = p[31:0]; end
         2'd2: if (y == 0) dz = 1'b1;
               else begin q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0]; end
         default: if (y == 0) dz = 1'b1;
                  else begin l = x / y; h = x % y; end
      endcase
   endtask

   // Issue one op; optionally pulse a bogus start while busy
   task automatic run(input logic [1:0] o, input logic [31:0] x, y,
                      input int glitch, output int lat);
      @(negedge clock);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("busy_e0", {31'b0, busy}, 1);
      check("done_e0", {31'b0, done}, 0);
      op = 2'($urandom); a = $urandom; b = $urandom;
      lat = 0;
      do begin
         @(posedge clock); #1;
         lat++;
         start = (lat == glitch);
         if (start) begin op = 2'd3; a = 32'd50; b = '0; end
      end while (!done && lat < 100);
      start = 1'b0;
      check("done_seen", {31'b0, done}, 1);
   endtask

   task automatic check_result(input string tag, input int lat, exp_lat,
                               input logic dz);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_hi"}, hi, mhi);
      check({tag, "_lo"}, lo, mlo);
      check({tag, "_dz"}, {31'b0, div_zero}, {31'b0, dz});
      check({tag, "_busy"}, {31'b0, busy}, 0);
   endtask

   initial begin
      int   lat;
      logic dz;
      logic [1:0] o;
      logic [31:0] x, y;

      tv[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
      tv[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 33};
      tv[2] = '{2'd0, 32'hFFFFFFFD, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 33};
      tv[3] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
      tv[4] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
      tv[5] = '{2'd3, 32'd100,      32'd0,        32'd2,        32'd14,       1'b1, 1};
      tv[6] = '{2'd1, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0, 33};
      tv[7] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
      tv[8] = '{2'd1, 32'd5,        32'd6,        32'd0,        32'd30,       1'b0, 33};

      reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_dz", {31'b0, div_zero}, 0);
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);

      // back-to-back, so each start after the first lands in a done cycle
      for (int i = 0; i < 9; i++) begin
         run(tv[i].op, tv[i].a, tv[i].b, 0, lat);
         mhi = tv[i].hi;
         mlo = tv[i].lo;
         check_result($sformatf("vec%0d", i), lat, tv[i].lat, tv[i].dz);
      end

      // start while busy must be ignored
      run(2'd1, 32'd7, 32'd9, 5, lat);
      mhi = 32'd0; mlo = 32'd63;
      check_result("busy_start", lat, 33, 1'b0);

      // asynchronous reset mid-operation
      @(negedge clock);
      op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      #3 reset = 1'b0;
      #1;
      check("mid_rst_busy", {31'b0, busy}, 0);
      check("mid_rst_done", {31'b0, done}, 0);
      check("mid_rst_hi", hi, 0);
      check("mid_rst_lo", lo, 0);
      @(negedge clock);
      reset = 1'b1;
      mhi = '0; mlo = '0;
      run(2'd1, 32'd3, 32'd4, 0, lat);
      mlo = 32'd12;
      check_result("post_rst", lat, 33, 1'b0);

      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         if ($urandom_range(0, 7) == 0) x = 32'h80000000;
         case ($urandom_range(0, 7))
            0:       y = '0;
            1:       y = 32'hFFFFFFFF;
            2, 3:    y = 32'($urandom_range(1, 15));
            default: y = $urandom;
         endcase
         model(o, x, y, mhi, mlo, dz);
         run(o, x, y, (i % 3 == 0) ? 7 : 0, lat);
         check_result($sformatf("rnd%0d", i), lat, dz ? 1 : 33, dz);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
